// File: rtl/syncgen_pkg.sv
// rtl/syncgen_pkg.sv - shared constants and pulse-type enum for the composite sync generator
package syncgen_pkg;

    localparam logic [5:0] SYNC_LEVEL        = 6'd0;
    localparam int         ACTIVE_FIRST_LINE = 23;
    localparam int         EQ_CLKS           = 56;
    localparam int         BROAD_CLKS        = 655;
    localparam int         HALF_LINE         = 768;

    typedef enum logic [1:0] {
        PT_NORMAL,
        PT_EQ,
        PT_BROAD
    } pulse_t;

endpackage

// File: rtl/syncgen_linetimer.sv
// rtl/syncgen_linetimer.sv - hcnt/line counters and per-line pulse-type decode
// Serrated vertical interval selected by SYNCGEN_SERRATION_EN.
module syncgen_linetimer
    import syncgen_pkg::*;
#(
    parameter int LINE_CLKS = 1536,
    parameter int LINES     = 312,
    parameter int HW        = $clog2(LINE_CLKS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ce,
    output logic [HW-1:0] hcnt,
    output logic [8:0]    line,
    output logic [HW-1:0] hcnt_nxt,
    output logic [8:0]    line_nxt,
    output pulse_t        ptype
);

    logic [HW-1:0] hcnt_q, hcnt_d;
    logic [8:0]    line_q, line_d;

    always_comb begin
        hcnt_nxt = hcnt_q + HW'(1);
        line_nxt = line_q;
        if (hcnt_q == HW'(LINE_CLKS - 1)) begin
            hcnt_nxt = '0;
            line_nxt = (line_q == 9'(LINES - 1)) ? 9'd0 : line_q + 9'd1;
        end
        hcnt_d = ce ? hcnt_nxt : hcnt_q;
        line_d = ce ? line_nxt : line_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt_q <= '0;
            line_q <= '0;
        end else begin
            hcnt_q <= hcnt_d;
            line_q <= line_d;
        end
    end

    always_comb begin
        ptype = PT_NORMAL;
`ifdef SYNCGEN_SERRATION_EN
        if (line_q < 9'd3)
            ptype = PT_BROAD;
        else if (line_q < 9'd5 || line_q >= 9'(LINES - 2))
            ptype = PT_EQ;
`endif
    end

    assign hcnt = hcnt_q;
    assign line = line_q;

endmodule

// File: rtl/syncgen.sv
// rtl/syncgen.sv - PAL-style composite sync/video generator with registered cvbs output
// Serration/equalising pulses enabled by defining SYNCGEN_SERRATION_EN.
module syncgen
    import syncgen_pkg::*;
#(
    parameter real CLK             = 24e6,
    parameter int  LINE_CLKS       = 1536,
    parameter int  HSYNC_CLKS      = 113,
    parameter int  BACKPORCH_CLKS  = 128,
    parameter int  FRONTPORCH_CLKS = 40,
    parameter int  LINES           = 312,
    parameter int  BLACK_LEVEL     = 12
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ce,
    input  logic [5:0] video,
    output logic [5:0] cvbs,
    output logic       hsync,
    output logic       vsync,
    output logic       de,
    output logic [8:0] line
);

    localparam int HW = $clog2(LINE_CLKS);

    localparam logic [HW-1:0] ACT_START  = HW'(HSYNC_CLKS + BACKPORCH_CLKS);
    localparam logic [HW-1:0] ACT_END    = HW'(LINE_CLKS - FRONTPORCH_CLKS);
    localparam logic [HW-1:0] HS_END     = HW'(HSYNC_CLKS);
    localparam logic [HW-1:0] EQ_END     = HW'(EQ_CLKS);
    localparam logic [HW-1:0] BROAD_END  = HW'(BROAD_CLKS);
    localparam logic [HW-1:0] HALF       = HW'(HALF_LINE);
    localparam logic [HW-1:0] EQ2_END    = HW'(HALF_LINE + EQ_CLKS);
    localparam logic [HW-1:0] BROAD2_END = HW'(HALF_LINE + BROAD_CLKS);
    localparam logic [8:0]    ACT_FIRST  = 9'(ACTIVE_FIRST_LINE);
    localparam logic [8:0]    ACT_LAST   = 9'(LINES - 3);
    localparam logic [5:0]    BLACK6     = 6'(BLACK_LEVEL);

    if (CLK <= 0.0 || ACT_START >= ACT_END || LINES < ACTIVE_FIRST_LINE + 3) begin : g_bad_cfg
        $error("syncgen: inconsistent timing parameters");
    end

    logic [HW-1:0] hcnt, hcnt_nxt;
    logic [8:0]    line_cur, line_nxt;
    pulse_t        ptype;

    syncgen_linetimer #(
        .LINE_CLKS (LINE_CLKS),
        .LINES     (LINES),
        .HW        (HW)
    ) u_linetimer (
        .clk      (clk),
        .rst_n    (rst_n),
        .ce       (ce),
        .hcnt     (hcnt),
        .line     (line_cur),
        .hcnt_nxt (hcnt_nxt),
        .line_nxt (line_nxt),
        .ptype    (ptype)
    );

    function automatic logic in_active(input logic [HW-1:0] hc, input logic [8:0] ln);
        return (hc >= ACT_START) && (hc < ACT_END) && (ln >= ACT_FIRST) && (ln <= ACT_LAST);
    endfunction

    logic       sync_lvl;
    logic [6:0] pix_sum;
    logic [5:0] pix;

    always_comb begin
        sync_lvl = 1'b0;
        case (ptype)
            PT_EQ:    sync_lvl = (hcnt < EQ_END) || (hcnt >= HALF && hcnt < EQ2_END);
            PT_BROAD: sync_lvl = (hcnt < BROAD_END) || (hcnt >= HALF && hcnt < BROAD2_END);
            default:  sync_lvl = (hcnt < HS_END);
        endcase
    end

    // 7-bit sum so bright luma clips at full scale instead of wrapping into sync
    assign pix_sum = {1'b0, video} + {1'b0, BLACK6};
    assign pix     = pix_sum[6] ? 6'd63 : pix_sum[5:0];

    logic [5:0] cvbs_q, cvbs_d;
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;
    logic       de_q, de_d;

    always_comb begin
        cvbs_d  = cvbs_q;
        hsync_d = hsync_q;
        vsync_d = vsync_q;
        de_d    = de_q;
        if (ce) begin
            hsync_d = !sync_lvl;
            vsync_d = !(line_cur < 9'd3);
            // de looks one tick ahead so the pixel source has a tick to respond
            de_d    = in_active(hcnt_nxt, line_nxt);
            if (sync_lvl)
                cvbs_d = SYNC_LEVEL;
            else if (in_active(hcnt, line_cur))
                cvbs_d = pix;
            else
                cvbs_d = BLACK6;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cvbs_q  <= BLACK6;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            de_q    <= 1'b0;
        end else begin
            cvbs_q  <= cvbs_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            de_q    <= de_d;
        end
    end

    assign cvbs  = cvbs_q;
    assign hsync = hsync_q;
    assign vsync = vsync_q;
    assign de    = de_q;
    assign line  = line_cur;

endmodule

// File: doc/syncgen.md
SYNCGEN -- requirements
Module: syncgen

Interface
REQ-001 Parameters SHALL be: CLK, 24e6, system clock rate in Hz (informational only).
REQ-002 LINE_CLKS, 1536, ce-ticks per line (64 us).
REQ-003 HSYNC_CLKS, 113, normal line sync width in ticks.
REQ-004 BACKPORCH_CLKS, 128, back porch width in ticks.
REQ-005 FRONTPORCH_CLKS, 40, front porch width in ticks.
REQ-006 LINES, 312, lines per frame (progressive).
REQ-007 BLACK_LEVEL, 12, cvbs code for black.
REQ-008 Ports SHALL be: clk  input  1  system clock, all state on posedge.
REQ-009 rst_n  input  1  reset, asynchronous, active-low.
REQ-010 ce  input  1  clock enable; state advances only on ticks where ce=1.
REQ-011 video  input  6  luma above black, sampled on ticks with de=1.
REQ-012 cvbs  output  6  registered composite output.
REQ-013 hsync  output  1  active-low; low whenever cvbs is at sync level.
REQ-014 vsync  output  1  active-low; low for all of lines 0..2.
REQ-015 de  output  1  pixel request, asserted one tick before the pixel appears on cvbs.
REQ-016 line  output  9  current line number, 0..LINES-1.

Function
REQ-017 hcnt SHALL count 0..LINE_CLKS-1, wrap to 0 and increment line; line SHALL wrap LINES-1 -> 0 on the same tick.
REQ-018 Line pulse type: lines 0..2 BROAD; lines 3..4 and LINES-2..LINES-1 EQ; all others NORMAL.
REQ-019 NORMAL: sync level for hcnt in [0, HSYNC_CLKS).
REQ-020 EQ: sync level for hcnt in [0,56) and [768,824).
REQ-021 BROAD: sync level for hcnt in [0,655) and [768,1423).
REQ-022 Active window: hcnt in [HSYNC_CLKS+BACKPORCH_CLKS, LINE_CLKS-FRONTPORCH_CLKS) = [241,1496), lines ACTIVE_FIRST_LINE(23)..LINES-3.
REQ-023 de SHALL be high exactly on the ticks one before each active-window tick.
REQ-024 cvbs SHALL be 0 (SYNC_LEVEL) at sync level, min(BLACK_LEVEL+video, 63) in the active window using a 7-bit sum, and BLACK_LEVEL otherwise.
REQ-025 cvbs, hsync and vsync SHALL change on the same tick (1-tick registered latency from the hcnt decode).
REQ-026 While ce=0, all state and outputs SHALL hold.

Reset
REQ-027 rst_n low SHALL immediately force hcnt=0, line=0, cvbs=BLACK_LEVEL, hsync=1, vsync=1, de=0, including mid-line.
REQ-028 The first ce tick after release SHALL start line 0 (BROAD) at hcnt 0.

Configuration
REQ-029 SYNCGEN_SERRATION_EN defined: pulse types SHALL follow REQ-018..021.
REQ-030 SYNCGEN_SERRATION_EN undefined: every line SHALL be NORMAL, and vsync SHALL still be low for lines 0..2.

Structure
REQ-031 Package syncgen_pkg SHALL hold SYNC_LEVEL, ACTIVE_FIRST_LINE, the EQ/BROAD pulse widths, the half-line offset 768, and the pulse-type enum PT_NORMAL/PT_EQ/PT_BROAD.
REQ-032 Sub-module syncgen_linetimer SHALL own the hcnt/line counters, wrap logic and pulse-type decode.

Verification
REQ-033 Reset, then ce=1 for one line -> line 0: cvbs=0 and hsync=0 for ticks 0..654 and 768..1422, vsync=0 throughout.
REQ-034 Line 10 -> hsync low exactly 113 ticks, cvbs=12 elsewhere, de=0 all line.
REQ-035 Line 100, video=20 -> de high 1255 ticks, cvbs=32 one tick later; video=63 -> cvbs=63 (saturated).
REQ-036 ce high 1 of 4 clk -> frame period 4*1536*312 clk; outputs constant while ce=0.
REQ-037 rst_n pulsed low at line 100, hcnt 500 -> same-cycle cvbs=12, hsync=1, de=0; restart at line 0, hcnt 0.
REQ-038 SYNCGEN_SERRATION_EN undefined -> line 0: 113-tick sync only, vsync=0.
